// File: rtl/cpu_prefetch.sv
// cpu_prefetch: credit-limited instruction prefetch queue with in-order tag FIFO and redirect flush
`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef BOOT_ADDR
`define BOOT_ADDR 32'h0000_1000
`endif
`ifndef EXCEPTION_ADDR
`define EXCEPTION_ADDR 32'h0000_0080
`endif
module cpu_prefetch #(
  parameter int ADDR_WIDTH = `VIRTUAL_ADDR_WIDTH,
  parameter int DATA_WIDTH = `REG_WIDTH,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = `BOOT_ADDR,
  parameter logic [ADDR_WIDTH-1:0] EXCEPTION_ADDR = `EXCEPTION_ADDR,
  parameter int PC_STEP = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exception,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  resp_fault,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_fault
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0] count, outstanding, drop;
  logic [PW-1:0] q_head, q_tail, t_head, t_tail;
  logic [DATA_WIDTH-1:0] q_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc [DEPTH];
  logic [ADDR_WIDTH-1:0] tags [DEPTH];
  logic [DEPTH-1:0] q_fault;
  logic redirect, issue, enq, deq;
  logic [CW:0] inflight;
  always_comb begin
    redirect = exception | jump;
    inflight = {1'b0, count} + {1'b0, outstanding};
    // queue slots are reserved at issue time, so a response always has room
    req_valid = !reset && state == RUN && !redirect && inflight < FULL;
    req_addr = pc;
    issue = req_valid && req_ready;
    enq = !reset && !redirect && resp_valid && drop == '0;
    out_valid = !reset && count != '0;
    deq = out_valid && out_ready;
    out_instr = q_instr[q_head];
    out_pc = q_pc[q_head];
    out_fault = q_fault[q_head];
    state_next = redirect ? RUN : ((enq && resp_fault) ? HALT : state);
  end
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else state <= state_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= BOOT_ADDR;
      count <= '0;
      outstanding <= '0;
      drop <= '0;
      q_head <= '0;
      q_tail <= '0;
      t_head <= '0;
      t_tail <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp_valid);
      if (resp_valid) t_head <= t_head + PW'(1);
      if (issue) t_tail <= t_tail + PW'(1);
      if (redirect) begin
        pc <= exception ? EXCEPTION_ADDR : jump_pc;
        count <= '0;
        q_head <= '0;
        q_tail <= '0;
        drop <= outstanding - CW'(resp_valid);
      end else begin
        if (issue) pc <= pc + ADDR_WIDTH'(PC_STEP);
        if (resp_valid && drop != '0) drop <= drop - CW'(1);
        if (enq) q_tail <= q_tail + PW'(1);
        if (deq) q_head <= q_head + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (issue) tags[t_tail] <= pc;
    if (enq) begin
      q_instr[q_tail] <= resp_data;
      q_pc[q_tail] <= tags[t_head];
      q_fault[q_tail] <= resp_fault;
    end
  end
endmodule

// File: tb/tb_cpu_prefetch.sv
// tb_cpu_prefetch: scoreboard bench with an in-order 1-cycle memory model that can be held off
module tb_cpu_prefetch;
  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam logic [31:0] EXC = 32'h0000_0080;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic fault;} exp_t;
  typedef struct {logic [31:0] addr; logic stale;} mem_t;
  logic clock = 0, reset = 1, exception = 0, jump = 0;
  logic [31:0] jump_pc = 0;
  logic req_valid, req_ready = 0;
  logic [31:0] req_addr;
  logic resp_valid = 0, resp_fault = 0;
  logic [31:0] resp_data = 0;
  logic out_valid, out_ready = 0, out_fault;
  logic [31:0] out_instr, out_pc;
  logic [31:0] resp_pc = 0, fault_addr = 32'h1;
  logic resp_stale = 0, mem_hold = 0;
  exp_t sb[$];
  mem_t mem_q[$];
  int checks = 0, passed = 0, accepts = 0;
  cpu_prefetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .BOOT_ADDR(BOOT),
    .EXCEPTION_ADDR(EXC), .PC_STEP(4)) dut (
    .clock(clock), .reset(reset), .exception(exception), .jump(jump), .jump_pc(jump_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault));
  always #5 clock = ~clock;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  task automatic tick();
    exp_t e;
    mem_t m;
    logic red;
    #1;
    red = exception || jump;
    if (reset) begin
      mem_q.delete();
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) $display("FAIL deq_unexpected: got out_pc=%h, required no output", out_pc);
        else begin
          e = sb.pop_front();
          if (out_pc !== e.pc || out_instr !== e.instr || out_fault !== e.fault)
            $display("FAIL deq_head: got pc=%h instr=%h fault=%b, required pc=%h instr=%h fault=%b",
              out_pc, out_instr, out_fault, e.pc, e.instr, e.fault);
          else passed++;
        end
      end
      if (resp_valid && !resp_stale && !red) sb.push_back('{resp_pc, mem_word(resp_pc), resp_pc == fault_addr});
      if (red) begin
        sb.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      end
      if (req_valid && req_ready) begin
        mem_q.push_back('{req_addr, 1'b0});
        accepts++;
      end
    end
    @(posedge clock);
    @(negedge clock);
    resp_valid = 0;
    if (!mem_hold && mem_q.size() > 0) begin
      m = mem_q.pop_front();
      resp_valid = 1;
      resp_pc = m.addr;
      resp_stale = m.stale;
      resp_data = mem_word(m.addr);
      resp_fault = m.addr == fault_addr;
    end
  endtask
  task automatic reset_dut();
    reset = 1; exception = 0; jump = 0; mem_hold = 0; req_ready = 0; out_ready = 0;
    tick();
    tick();
    reset = 0;
    accepts = 0;
  endtask
  task automatic drain();
    req_ready = 0;
    out_ready = 1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (sb.size() == 0 && mem_q.size() == 0 && !resp_valid && !out_valid) break;
      tick();
    end
    #1;
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0)
      $display("FAIL drain: got %0d expected entries left, out_valid=%b, required 0 and 0", sb.size(), out_valid);
    else passed++;
  endtask
  task automatic test_reset();
    reset = 1;
    req_ready = 1;
    out_ready = 1;
    tick();
    tick();
    #1;
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_outputs: got req_valid=%b out_valid=%b, required 0 0", req_valid, out_valid);
    else passed++;
    reset = 0;
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== BOOT)
      $display("FAIL reset_release: got req_valid=%b req_addr=%h, required 1 %h", req_valid, req_addr, BOOT);
    else passed++;
  endtask
  task automatic test_stream();
    for (int k = 0; k < 7; k++) begin
      #1;
      checks++;
      if (k < 2 ? out_valid !== 1'b0 : (out_valid !== 1'b1 || out_pc !== BOOT + 32'(4 * (k - 2))))
        $display("FAIL stream_cycle%0d: got out_valid=%b out_pc=%h, required valid=%b pc=%h",
          k, out_valid, out_pc, k >= 2, BOOT + 32'(4 * (k - 2)));
      else passed++;
      tick();
    end
    drain();
  endtask
  task automatic test_backpressure();
    reset_dut();
    req_ready = 1;
    repeat (10) tick();
    #1;
    checks++;
    if (accepts != 4 || req_valid !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL full_stall: got accepts=%0d req_valid=%b out_valid=%b, required 4 0 1", accepts, req_valid, out_valid);
    else passed++;
    out_ready = 1;
    tick();
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== BOOT + 32'd16)
      $display("FAIL resume_issue: got req_valid=%b req_addr=%h, required 1 %h", req_valid, req_addr, BOOT + 32'd16);
    else passed++;
    drain();
  endtask
  task automatic test_jump();
    reset_dut();
    out_ready = 1;
    mem_hold = 1;
    req_ready = 1;
    repeat (3) tick();
    req_ready = 0;
    #1;
    checks++;
    if (accepts != 3) $display("FAIL jump_setup: got %0d requests, required 3", accepts);
    else passed++;
    jump = 1;
    jump_pc = 32'h100;
    tick();
    jump = 0;
    req_ready = 1;
    mem_hold = 0;
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h100)
      $display("FAIL jump_target: got req_valid=%b req_addr=%h, required 1 00000100", req_valid, req_addr);
    else passed++;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100)
      $display("FAIL jump_first_out: got out_valid=%b out_pc=%h, required 1 00000100", out_valid, out_pc);
    else passed++;
    drain();
  endtask
  task automatic test_priority();
    reset_dut();
    req_ready = 1;
    out_ready = 1;
    repeat (3) tick();
    exception = 1;
    jump = 1;
    jump_pc = 32'h200;
    tick();
    exception = 0;
    jump = 0;
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== EXC)
      $display("FAIL exc_priority: got req_valid=%b req_addr=%h, required 1 %h", req_valid, req_addr, EXC);
    else passed++;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== EXC)
      $display("FAIL exc_first_out: got out_valid=%b out_pc=%h, required 1 %h", out_valid, out_pc, EXC);
    else passed++;
    drain();
  endtask
  task automatic test_fault();
    reset_dut();
    out_ready = 1;
    fault_addr = 32'h20;
    jump = 1;
    jump_pc = 32'h20;
    tick();
    jump = 0;
    req_ready = 1;
    tick();
    req_ready = 0;
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_pc !== 32'h20)
      $display("FAIL fault_enq: got out_valid=%b out_fault=%b out_pc=%h, required 1 1 00000020", out_valid, out_fault, out_pc);
    else passed++;
    req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      checks++;
      if (req_valid !== 1'b0) $display("FAIL halt_cycle%0d: got req_valid=%b, required 0", k, req_valid);
      else passed++;
    end
    jump = 1;
    jump_pc = 32'h40;
    tick();
    jump = 0;
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h40)
      $display("FAIL halt_exit: got req_valid=%b req_addr=%h, required 1 00000040", req_valid, req_addr);
    else passed++;
    drain();
    fault_addr = 32'h1;
  endtask
  task automatic test_wrap();
    reset_dut();
    req_ready = 1;
    out_ready = 1;
    jump = 1;
    jump_pc = 32'hFFFF_FFFC;
    tick();
    jump = 0;
    #1;
    checks++;
    if (req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_start: got req_addr=%h, required fffffffc", req_addr);
    else passed++;
    tick();
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0)
      $display("FAIL wrap_zero: got req_valid=%b req_addr=%h, required 1 00000000", req_valid, req_addr);
    else passed++;
    drain();
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_priority();
    test_fault();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end
endmodule
